mem_port_arbiter: RTL and testbench

Shares the single memory command port between two requesters.
- Write requester: the host/SPI command decoder's write stream.
- Read requester: the LED display refresh scanner fetching pixel data.

The block issues at most one memory command per cycle. It honours the memory FIFO back-pressure, bounds outstanding reads and routes returned read data back to the scanner. Reads win by default; a starvation limit guarantees write progress.

---
 rtl/mem_arb_pkg.sv | 18 +
 rtl/mem_arb_rd_tracker.sv | 45 ++++
 rtl/mem_port_arbiter.sv | 95 +++++++++
 tb/tb_mem_port_arbiter.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory port arbiter: command encodings,
// grant encoding and default parameter values.
package mem_arb_pkg;

  localparam logic CMD_READ  = 1'b0;
  localparam logic CMD_WRITE = 1'b1;

  localparam int DEF_ADDRESS_WIDTH   = 25;
  localparam int DEF_MAX_OUTSTANDING = 4;
  localparam int DEF_STARVE_LIMIT    = 8;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_RD   = 2'd1,
    GNT_WR   = 2'd2
  } grant_t;

endpackage

// File: rtl/mem_arb_rd_tracker.sv
// Tracks reads issued but not yet returned, registers returned data for the
// scanner and flags returns that arrive with nothing outstanding.
module mem_arb_rd_tracker
  import mem_arb_pkg::*;
#(
  parameter int MAX_OUTSTANDING = DEF_MAX_OUTSTANDING
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rd_issue,
  input  logic [7:0] data_in_mem,
  input  logic       data_in_ready_mem,
  output logic       rd_room,
  output logic [7:0] rd_data,
  output logic       rd_data_valid,
  output logic       rd_unexpected
);

  logic [3:0] outstanding;

  assign rd_room = (outstanding < 4'(MAX_OUTSTANDING));

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      outstanding   <= '0;
      rd_data       <= '0;
      rd_data_valid <= 1'b0;
      rd_unexpected <= 1'b0;
    end else begin
      rd_data       <= data_in_mem;
      rd_data_valid <= data_in_ready_mem;
      // A return with nothing outstanding must not underflow; only a
      // simultaneous issue can then leave a read in flight.
      if (data_in_ready_mem && outstanding == '0) begin
        rd_unexpected <= 1'b1;
        outstanding   <= rd_issue ? 4'd1 : 4'd0;
      end else if (rd_issue && !data_in_ready_mem) begin
        outstanding <= outstanding + 4'd1;
      end else if (!rd_issue && data_in_ready_mem) begin
        outstanding <= outstanding - 4'd1;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the memory command port between the host write stream and the LED
// scanner read stream; reads win unless writes have been starved too long.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDRESS_WIDTH   = DEF_ADDRESS_WIDTH,
  parameter int MAX_OUTSTANDING = DEF_MAX_OUTSTANDING,
  parameter int STARVE_LIMIT    = DEF_STARVE_LIMIT
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     wr_req,
  input  logic [ADDRESS_WIDTH-1:0] wr_address,
  input  logic [7:0]               wr_data,
  output logic                     wr_ack,
  input  logic                     rd_req,
  input  logic [ADDRESS_WIDTH-1:0] rd_address,
  output logic                     rd_ack,
  output logic [7:0]               rd_data,
  output logic                     rd_data_valid,
  output logic                     rd_unexpected,
  output logic [ADDRESS_WIDTH-1:0] address_mem,
  output logic                     wr_mem,
  output logic [7:0]               data_out_mem,
  output logic                     data_out_ready_mem,
  input  logic                     fifo_full_mem,
  input  logic [7:0]               data_in_mem,
  input  logic                     data_in_ready_mem
);

  grant_t     grant;
  logic       wr_elig;
  logic       rd_elig;
  logic       rd_room;
  logic [7:0] starve_cnt;

  // The ack cycle is excluded: the requester still holds its request then.
  assign wr_elig = wr_req && !wr_ack;
  assign rd_elig = rd_req && !rd_ack && rd_room;

  always_comb begin
    grant = GNT_NONE;
    if (!fifo_full_mem) begin
      if (wr_elig && rd_elig)
        grant = (starve_cnt == 8'(STARVE_LIMIT)) ? GNT_WR : GNT_RD;
      else if (wr_elig)
        grant = GNT_WR;
      else if (rd_elig)
        grant = GNT_RD;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      data_out_ready_mem <= 1'b0;
      address_mem        <= '0;
      wr_mem             <= 1'b0;
      data_out_mem       <= '0;
      wr_ack             <= 1'b0;
      rd_ack             <= 1'b0;
      starve_cnt         <= '0;
    end else begin
      data_out_ready_mem <= (grant != GNT_NONE);
      wr_ack             <= (grant == GNT_WR);
      rd_ack             <= (grant == GNT_RD);
      if (grant == GNT_WR) begin
        address_mem  <= wr_address;
        wr_mem       <= CMD_WRITE;
        data_out_mem <= wr_data;
      end else if (grant == GNT_RD) begin
        address_mem <= rd_address;
        wr_mem      <= CMD_READ;
      end
      if (grant == GNT_WR || !wr_req)
        starve_cnt <= '0;
      else if (grant == GNT_RD && wr_elig && starve_cnt != 8'(STARVE_LIMIT))
        starve_cnt <= starve_cnt + 8'd1;
    end
  end

  mem_arb_rd_tracker #(
    .MAX_OUTSTANDING(MAX_OUTSTANDING)
  ) u_rd_tracker (
    .clk              (clk),
    .reset_n          (reset_n),
    .rd_issue         (grant == GNT_RD),
    .data_in_mem      (data_in_mem),
    .data_in_ready_mem(data_in_ready_mem),
    .rd_room          (rd_room),
    .rd_data          (rd_data),
    .rd_data_valid    (rd_data_valid),
    .rd_unexpected    (rd_unexpected)
  );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter.
module tb_mem_port_arbiter;

  logic        clk;
  logic        reset_n;
  logic        wr_req;
  logic [24:0] wr_address;
  logic [7:0]  wr_data;
  logic        wr_ack;
  logic        rd_req;
  logic [24:0] rd_address;
  logic        rd_ack;
  logic [7:0]  rd_data;
  logic        rd_data_valid;
  logic        rd_unexpected;
  logic [24:0] address_mem;
  logic        wr_mem;
  logic [7:0]  data_out_mem;
  logic        data_out_ready_mem;
  logic        fifo_full_mem;
  logic [7:0]  data_in_mem;
  logic        data_in_ready_mem;

  int total;
  int bad;

  mem_port_arbiter #(
    .ADDRESS_WIDTH  (25),
    .MAX_OUTSTANDING(4),
    .STARVE_LIMIT   (8)
  ) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .wr_req            (wr_req),
    .wr_address        (wr_address),
    .wr_data           (wr_data),
    .wr_ack            (wr_ack),
    .rd_req            (rd_req),
    .rd_address        (rd_address),
    .rd_ack            (rd_ack),
    .rd_data           (rd_data),
    .rd_data_valid     (rd_data_valid),
    .rd_unexpected     (rd_unexpected),
    .address_mem       (address_mem),
    .wr_mem            (wr_mem),
    .data_out_mem      (data_out_mem),
    .data_out_ready_mem(data_out_ready_mem),
    .fifo_full_mem     (fifo_full_mem),
    .data_in_mem       (data_in_mem),
    .data_in_ready_mem (data_in_ready_mem)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Inputs change and outputs are sampled on the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    step();
    step();
    total++;
    if ({data_out_ready_mem, wr_ack, rd_ack, rd_data_valid, rd_unexpected, wr_mem} !== 6'b0) begin
      bad++;
      $display("FAIL reset_flags: got %b want 000000",
               {data_out_ready_mem, wr_ack, rd_ack, rd_data_valid, rd_unexpected, wr_mem});
    end
    total++;
    if (address_mem !== 25'h0 || data_out_mem !== 8'h00 || rd_data !== 8'h00) begin
      bad++;
      $display("FAIL reset_buses: addr=%h dout=%h rdata=%h want all 0", address_mem, data_out_mem, rd_data);
    end
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_single_write();
    wr_req = 1'b1; wr_address = 25'h0000010; wr_data = 8'hA5;
    step();
    total++;
    if (data_out_ready_mem !== 1'b1 || wr_mem !== 1'b1 || wr_ack !== 1'b1 || rd_ack !== 1'b0) begin
      bad++;
      $display("FAIL write_issue: dorm=%b wr_mem=%b wr_ack=%b rd_ack=%b want 1 1 1 0",
               data_out_ready_mem, wr_mem, wr_ack, rd_ack);
    end
    total++;
    if (address_mem !== 25'h10 || data_out_mem !== 8'hA5) begin
      bad++;
      $display("FAIL write_payload: addr=%h data=%h want 0000010 a5", address_mem, data_out_mem);
    end
    step();
    total++;
    if (data_out_ready_mem !== 1'b0 || wr_ack !== 1'b0) begin
      bad++;
      $display("FAIL write_ack_gap: dorm=%b wr_ack=%b want 0 0", data_out_ready_mem, wr_ack);
    end
    wr_req = 1'b0;
    step();
  endtask

  task automatic test_outstanding_limit();
    int unsigned acks;
    acks = 0;
    rd_req = 1'b1; rd_address = 25'h0000100;
    for (int i = 0; i < 10; i++) begin
      step();
      if (rd_ack) acks++;
    end
    total++;
    if (acks !== 4) begin
      bad++;
      $display("FAIL outstanding_acks: got %0d want 4", acks);
    end
    total++;
    if (data_out_ready_mem !== 1'b0) begin
      bad++;
      $display("FAIL outstanding_block: dorm=%b want 0", data_out_ready_mem);
    end
    data_in_mem = 8'h3C; data_in_ready_mem = 1'b1;
    step();
    data_in_ready_mem = 1'b0;
    total++;
    if (rd_data_valid !== 1'b1 || rd_data !== 8'h3C || rd_ack !== 1'b0) begin
      bad++;
      $display("FAIL return_data: valid=%b data=%h rd_ack=%b want 1 3c 0", rd_data_valid, rd_data, rd_ack);
    end
    step();
    total++;
    if (rd_ack !== 1'b1 || data_out_ready_mem !== 1'b1 || wr_mem !== 1'b0 ||
        address_mem !== 25'h100 || rd_data_valid !== 1'b0) begin
      bad++;
      $display("FAIL read_after_return: rd_ack=%b dorm=%b wr_mem=%b addr=%h valid=%b want 1 1 0 0000100 0",
               rd_ack, data_out_ready_mem, wr_mem, address_mem, rd_data_valid);
    end
    rd_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      data_in_mem = 8'(i + 64); data_in_ready_mem = 1'b1;
      step();
      total++;
      if (rd_data_valid !== 1'b1 || rd_data !== 8'(i + 64)) begin
        bad++;
        $display("FAIL drain_%0d: valid=%b data=%h want 1 %h", i, rd_data_valid, rd_data, 8'(i + 64));
      end
    end
    data_in_ready_mem = 1'b0;
    step();
    total++;
    if (rd_unexpected !== 1'b0) begin
      bad++;
      $display("FAIL drain_unexpected: got %b want 0", rd_unexpected);
    end
  endtask

  task automatic test_back_to_back();
    wr_req = 1'b1; wr_address = 25'h0000020; wr_data = 8'h5C;
    rd_req = 1'b1; rd_address = 25'h0000120;
    for (int i = 0; i < 8; i++) begin
      step();
      total++;
      if (data_out_ready_mem !== 1'b1 || wr_mem !== 1'((i % 2) == 1)) begin
        bad++;
        $display("FAIL alternate_%0d: dorm=%b wr_mem=%b want 1 %b", i, data_out_ready_mem, wr_mem,
                 1'((i % 2) == 1));
      end
      data_in_ready_mem = rd_ack;
    end
    wr_req = 1'b0; rd_req = 1'b0;
    step();
    data_in_ready_mem = 1'b0;
    step();
  endtask

  task automatic test_starvation();
    int unsigned ncmd;
    logic        exp_wr;
    ncmd = 0;
    wr_req = 1'b1; wr_address = 25'h0000200; wr_data = 8'h11;
    rd_req = 1'b1; rd_address = 25'h0000300;
    // Full on every other cycle keeps both sides eligible at each grant.
    for (int cyc = 0; cyc < 40; cyc++) begin
      fifo_full_mem = ((cyc % 2) == 1);
      step();
      if (data_out_ready_mem) begin
        exp_wr = ((ncmd % 9) == 8);
        total++;
        if (wr_mem !== exp_wr || wr_ack !== exp_wr || rd_ack !== !exp_wr) begin
          bad++;
          $display("FAIL starve_cmd_%0d: wr_mem=%b wr_ack=%b rd_ack=%b want wr=%b",
                   ncmd, wr_mem, wr_ack, rd_ack, exp_wr);
        end
        if (exp_wr) begin
          total++;
          if (address_mem !== 25'h200 || data_out_mem !== 8'h11) begin
            bad++;
            $display("FAIL starve_wpayload_%0d: addr=%h data=%h want 0000200 11", ncmd, address_mem, data_out_mem);
          end
        end
        ncmd++;
      end
      data_in_ready_mem = rd_ack;
    end
    total++;
    if (ncmd !== 20) begin
      bad++;
      $display("FAIL starve_count: got %0d commands want 20", ncmd);
    end
    wr_req = 1'b0; rd_req = 1'b0; fifo_full_mem = 1'b0; data_in_ready_mem = 1'b0;
    step();
    step();
  endtask

  task automatic test_fifo_full();
    fifo_full_mem = 1'b1;
    wr_req = 1'b1; wr_address = 25'h0000030; wr_data = 8'h77;
    rd_req = 1'b1; rd_address = 25'h0000130;
    for (int i = 0; i < 5; i++) begin
      step();
      total++;
      if (data_out_ready_mem !== 1'b0) begin
        bad++;
        $display("FAIL full_hold_%0d: dorm=%b want 0", i, data_out_ready_mem);
      end
    end
    fifo_full_mem = 1'b0;
    step();
    total++;
    if (data_out_ready_mem !== 1'b1 || wr_mem !== 1'b0 || rd_ack !== 1'b1 || address_mem !== 25'h130) begin
      bad++;
      $display("FAIL full_release: dorm=%b wr_mem=%b rd_ack=%b addr=%h want 1 0 1 0000130",
               data_out_ready_mem, wr_mem, rd_ack, address_mem);
    end
    wr_req = 1'b0; rd_req = 1'b0; data_in_ready_mem = 1'b1;
    step();
    data_in_ready_mem = 1'b0;
    step();
  endtask

  task automatic test_same_cycle_return();
    int unsigned acks;
    acks = 0;
    rd_req = 1'b1; rd_address = 25'h0000400;
    step(); step(); step(); step();
    data_in_mem = 8'h77; data_in_ready_mem = 1'b1;
    step();
    data_in_ready_mem = 1'b0;
    total++;
    if (rd_ack !== 1'b1 || rd_data_valid !== 1'b1 || rd_data !== 8'h77) begin
      bad++;
      $display("FAIL same_cycle: rd_ack=%b valid=%b data=%h want 1 1 77", rd_ack, rd_data_valid, rd_data);
    end
    for (int i = 0; i < 8; i++) begin
      step();
      if (rd_ack) acks++;
    end
    total++;
    if (acks !== 2) begin
      bad++;
      $display("FAIL same_cycle_count: got %0d further reads want 2", acks);
    end
    rd_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      data_in_mem = 8'(i + 160); data_in_ready_mem = 1'b1;
      step();
    end
    total++;
    if (rd_unexpected !== 1'b0) begin
      bad++;
      $display("FAIL unexpected_early: got %b want 0", rd_unexpected);
    end
    data_in_mem = 8'hE1;
    step();
    data_in_ready_mem = 1'b0;
    total++;
    if (rd_unexpected !== 1'b1 || rd_data_valid !== 1'b1 || rd_data !== 8'hE1) begin
      bad++;
      $display("FAIL unexpected_set: flag=%b valid=%b data=%h want 1 1 e1", rd_unexpected, rd_data_valid, rd_data);
    end
    step(); step(); step();
    total++;
    if (rd_unexpected !== 1'b1) begin
      bad++;
      $display("FAIL unexpected_sticky: got %b want 1", rd_unexpected);
    end
  endtask

  task automatic test_reset_midop();
    int unsigned acks;
    acks = 0;
    rd_req = 1'b1; rd_address = 25'h0000500;
    for (int i = 0; i < 5; i++) begin
      step();
      if (rd_ack) acks++;
    end
    total++;
    if (acks !== 3) begin
      bad++;
      $display("FAIL midop_setup: got %0d reads want 3", acks);
    end
    reset_n = 1'b0;
    wr_req = 1'b1; wr_address = 25'h0000600; wr_data = 8'h99;
    step();
    total++;
    if ({data_out_ready_mem, wr_ack, rd_ack, rd_data_valid, rd_unexpected, wr_mem} !== 6'b0 ||
        address_mem !== 25'h0 || data_out_mem !== 8'h00 || rd_data !== 8'h00) begin
      bad++;
      $display("FAIL midop_reset: flags=%b addr=%h dout=%h rdata=%h want all 0",
               {data_out_ready_mem, wr_ack, rd_ack, rd_data_valid, rd_unexpected, wr_mem},
               address_mem, data_out_mem, rd_data);
    end
    reset_n = 1'b1; rd_req = 1'b0;
    data_in_mem = 8'h5A; data_in_ready_mem = 1'b1;
    step();
    data_in_ready_mem = 1'b0;
    total++;
    if (data_out_ready_mem !== 1'b1 || wr_ack !== 1'b1 || wr_mem !== 1'b1 ||
        address_mem !== 25'h600 || data_out_mem !== 8'h99) begin
      bad++;
      $display("FAIL midop_resume: dorm=%b wr_ack=%b wr_mem=%b addr=%h data=%h want 1 1 1 0000600 99",
               data_out_ready_mem, wr_ack, wr_mem, address_mem, data_out_mem);
    end
    total++;
    if (rd_unexpected !== 1'b1 || rd_data_valid !== 1'b1 || rd_data !== 8'h5A) begin
      bad++;
      $display("FAIL midop_abandoned: flag=%b valid=%b data=%h want 1 1 5a", rd_unexpected, rd_data_valid, rd_data);
    end
    wr_req = 1'b0;
    step();
    step();
  endtask

  initial begin
    total = 0;
    bad = 0;
    reset_n = 1'b0;
    wr_req = 1'b0; wr_address = '0; wr_data = '0;
    rd_req = 1'b0; rd_address = '0;
    fifo_full_mem = 1'b0; data_in_mem = '0; data_in_ready_mem = 1'b0;
    @(negedge clk);
    test_reset();
    test_single_write();
    test_outstanding_limit();
    test_back_to_back();
    test_starvation();
    test_fifo_full();
    test_same_cycle_return();
    test_reset_midop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
